// File: rtl/ark_axil_slave_pkg.sv
// rtl/ark_axil_slave_pkg.sv - shared constants, FSM state types and decode helpers for ark_axil_slave
package ark_axil_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_ADDR_W = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] IDX_STATE0  = 4'd0;
    localparam logic [3:0] IDX_KEY0    = 4'd4;
    localparam logic [3:0] IDX_RESULT0 = 4'd8;
    localparam logic [3:0] IDX_CTRL    = 4'd12;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 8;
    localparam int CTRL_BUSY_BIT  = 9;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    // RESULT words are read-only; everything above CTRL is a hole in the map.
    function automatic logic [1:0] wr_resp(input logic [3:0] idx);
        if (idx < IDX_RESULT0)     return RESP_OKAY;
        else if (idx < IDX_CTRL)   return RESP_SLVERR;
        else if (idx == IDX_CTRL)  return RESP_OKAY;
        else                       return RESP_DECERR;
    endfunction

    function automatic logic [1:0] rd_resp(input logic [3:0] idx);
        return (idx <= IDX_CTRL) ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/ark_axil_slave_if.sv
// rtl/ark_axil_slave_if.sv - AXI4-Lite bus bundle with master/slave modports
interface ark_axil_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/ark_axil_slave_xor_core.sv
// rtl/ark_axil_slave_xor_core.sv - registered 128-bit Add-Round-Key XOR with BUSY/DONE/irq sequencing
module ark_xor_core (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         clear_i,
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] result_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         done_irq_o
);

    logic [127:0] result_q, result_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         irq_q, irq_d;

    // Completion has priority so a clear can never swallow the DONE of an in-flight result.
    always_comb begin
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        irq_d    = 1'b0;
        if (busy_q) begin
            result_d = state_i ^ key_i;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            irq_d    = 1'b1;
        end else if (start_i) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (clear_i) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
        end
    end

    assign result_o   = result_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign done_irq_o = irq_q;

endmodule

// File: rtl/ark_axil_slave.sv
// rtl/ark_axil_slave.sv - AXI4-Lite responder for AES Add-Round-Key (STATE/KEY/RESULT/CTRL map)
// Optional ARK_WSTRB_EN: byte strobes honoured on STATE/KEY writes and gate START.
module ark_axil_slave
    import ark_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic       ACLK,
    input  logic       ARESET,
    ark_axil_if.slave  s_axi,
    output logic       done_irq
);

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata;

    assign awaddr = s_axi.S_AXI_AWADDR;
    assign araddr = s_axi.S_AXI_ARADDR;
    assign wdata  = s_axi.S_AXI_WDATA;

    // Word 0 sits in the most significant slot so the 128-bit view reads STATE0..STATE3.
    logic [0:3][31:0] state_q;
    logic [0:3][31:0] key_q;
    logic [0:3][31:0] result_w;
    logic             core_busy;
    logic             core_done;

    wr_state_e   wr_state_q, wr_state_d;
    logic [3:0]  aw_idx_q, aw_idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        aw_hs, w_hs, commit;

    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [3:0]  rd_idx;
    logic [31:0] rd_word;

    logic [31:0] wr_word;
    logic        start_ok;
    logic        start_pulse;
    logic        clear_done;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        s_axi.S_AXI_AWREADY = 1'b0;
        s_axi.S_AXI_WREADY  = 1'b0;
        s_axi.S_AXI_BVALID  = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                s_axi.S_AXI_AWREADY = !ARESET;
                s_axi.S_AXI_WREADY  = !ARESET;
            end
            W_HAVE_AW: s_axi.S_AXI_WREADY  = !ARESET;
            W_HAVE_W:  s_axi.S_AXI_AWREADY = !ARESET;
            W_COMMIT:  commit = 1'b1;
            W_RESP:    s_axi.S_AXI_BVALID  = 1'b1;
            default:   ;
        endcase

        aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
        w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
        if (aw_hs) aw_idx_d = awaddr[5:2];
        if (w_hs) begin
            wdata_d = wdata;
            wstrb_d = s_axi.S_AXI_WSTRB;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = W_COMMIT;
                else if (aw_hs)    wr_state_d = W_HAVE_AW;
                else if (w_hs)     wr_state_d = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  wr_state_d = W_COMMIT;
            W_HAVE_W:  if (aw_hs) wr_state_d = W_COMMIT;
            W_COMMIT: begin
                bresp_d    = wr_resp(aw_idx_q);
                wr_state_d = W_RESP;
            end
            W_RESP:    if (s_axi.S_AXI_BREADY) wr_state_d = W_IDLE;
            default:   wr_state_d = W_IDLE;
        endcase
    end

    assign s_axi.S_AXI_BRESP = bresp_q;

`ifdef ARK_WSTRB_EN
    always_comb begin
        logic [31:0] cur_word;
        cur_word = aw_idx_q[2] ? key_q[aw_idx_q[1:0]] : state_q[aw_idx_q[1:0]];
        for (int b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : cur_word[8*b +: 8];
        end
    end
    assign start_ok = wdata_q[CTRL_START_BIT] && wstrb_q[0];
`else
    assign wr_word  = wdata_q;
    assign start_ok = wdata_q[CTRL_START_BIT];
    logic unused_strb;
    assign unused_strb = ^wstrb_q;
`endif

    assign start_pulse = commit && (aw_idx_q == IDX_CTRL) && start_ok;
    assign clear_done  = commit && !aw_idx_q[3];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            state_q    <= '0;
            key_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            if (commit && aw_idx_q[3:2] == 2'b00) state_q[aw_idx_q[1:0]] <= wr_word;
            if (commit && aw_idx_q[3:2] == 2'b01) key_q[aw_idx_q[1:0]]   <= wr_word;
        end
    end

    assign rd_idx = araddr[5:2];

    always_comb begin
        rd_word = '0;
        case (rd_idx[3:2])
            2'b00:   rd_word = state_q[rd_idx[1:0]];
            2'b01:   rd_word = key_q[rd_idx[1:0]];
            2'b10:   rd_word = result_w[rd_idx[1:0]];
            default: begin
                if (rd_idx == IDX_CTRL) begin
                    rd_word[CTRL_DONE_BIT] = core_done;
                    rd_word[CTRL_BUSY_BIT] = core_busy;
                end
            end
        endcase
    end

    // Read data is captured from the register values before any same-cycle write commit lands.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        s_axi.S_AXI_ARREADY = (rd_state_q == R_IDLE) && !ARESET;
        s_axi.S_AXI_RVALID  = (rd_state_q == R_RESP);
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY) begin
                    rdata_d    = rd_word;
                    rresp_d    = rd_resp(rd_idx);
                    rd_state_d = R_RESP;
                end
            end
            R_RESP:  if (s_axi.S_AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.S_AXI_RDATA = rdata_q;
    assign s_axi.S_AXI_RRESP = rresp_q;

    ark_xor_core u_core (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .start_i    (start_pulse),
        .clear_i    (clear_done),
        .state_i    (state_q),
        .key_i      (key_q),
        .result_o   (result_w),
        .busy_o     (core_busy),
        .done_o     (core_done),
        .done_irq_o (done_irq)
    );

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr[1:0], araddr[1:0]};

endmodule

// File: tb/tb_ark_axil_slave.sv
// tb/tb_ark_axil_slave.sv - directed self-checking bench for ark_axil_slave
module tb_ark_axil_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_irq;
    int   n_checks = 0;
    int   n_fail   = 0;

    ark_axil_if axi ();

    ark_axil_slave dut (
        .ACLK     (clk),
        .ARESET   (rst),
        .s_axi    (axi),
        .done_irq (done_irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        int   t;
        aw_done = 1'b0;
        w_done  = 1'b0;
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = strb;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        t = 0;
        while (!(aw_done && w_done) && t < 50) begin
            aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            cyc(1);
            t++;
            if (aw_hs) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin axi.S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
        end
        if (!(aw_done && w_done)) begin
            n_checks++; n_fail++;
            $display("FAIL wr_addr_data_timeout addr=%h", addr);
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID  = 1'b0;
        end
        axi.S_AXI_BREADY = 1'b1;
        t = 0;
        while (!axi.S_AXI_BVALID && t < 50) begin
            cyc(1);
            t++;
        end
        if (!axi.S_AXI_BVALID) begin
            n_checks++; n_fail++;
            $display("FAIL wr_bresp_timeout addr=%h", addr);
            resp = 2'bxx;
        end else begin
            resp = axi.S_AXI_BRESP;
        end
        cyc(1);
        axi.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic done, hs;
        int   t;
        done = 1'b0;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!done && t < 50) begin
            hs = axi.S_AXI_ARREADY;
            cyc(1);
            t++;
            if (hs) begin axi.S_AXI_ARVALID = 1'b0; done = 1'b1; end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL rd_addr_timeout addr=%h", addr);
            axi.S_AXI_ARVALID = 1'b0;
        end
        axi.S_AXI_RREADY = 1'b1;
        t = 0;
        while (!axi.S_AXI_RVALID && t < 50) begin
            cyc(1);
            t++;
        end
        if (!axi.S_AXI_RVALID) begin
            n_checks++; n_fail++;
            $display("FAIL rd_data_timeout addr=%h", addr);
            data = 'x;
            resp = 2'bxx;
        end else begin
            data = axi.S_AXI_RDATA;
            resp = axi.S_AXI_RRESP;
        end
        cyc(1);
        axi.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] hs;
        rst = 1'b1;
        cyc(3);
        hs = {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID};
        n_checks++;
        if (hs !== 5'b0) begin n_fail++; $display("FAIL reset_ready_valid got=%b exp=00000", hs); end
        n_checks++;
        if ({axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA} !== 36'h0) begin
            n_fail++; $display("FAIL reset_resp_rdata got=%h exp=0", {axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA});
        end
        n_checks++;
        if (done_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", done_irq); end
        rst = 1'b0;
        cyc(1);
        hs = {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID};
        n_checks++;
        if (hs !== 5'b11100) begin n_fail++; $display("FAIL idle_ready got=%b exp=11100", hs); end
    endtask

    task automatic test_state_rw();
        logic [1:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i * 4), 32'(i + 1), 4'hF, r);
            n_checks++;
            if (r !== 2'b00) begin n_fail++; $display("FAIL state_wr_bresp[%0d] got=%b exp=00", i, r); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), d, r);
            n_checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                n_fail++; $display("FAIL state_rd[%0d] got=%h/%b exp=%h/00", i, d, r, i + 1);
            end
        end
    endtask

    task automatic test_compute();
        logic [31:0] st [4];
        logic [31:0] ky [4];
        logic [31:0] ex [4];
        logic [1:0]  r;
        logic [31:0] d;
        st = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        ky = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        ex = '{32'h00102030, 32'h40506070, 32'h8090A0B0, 32'hC0D0E0F0};
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i * 4), st[i], 4'hF, r);
            axi_write(6'(16 + i * 4), ky[i], 4'hF, r);
        end
        axi_write(6'h30, 32'h1, 4'hF, r);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL start_bresp got=%b exp=00", r); end
        n_checks++;
        if (done_irq !== 1'b1) begin n_fail++; $display("FAIL irq_pulse got=%b exp=1", done_irq); end
        cyc(1);
        n_checks++;
        if (done_irq !== 1'b0) begin n_fail++; $display("FAIL irq_one_cycle got=%b exp=0", done_irq); end
        axi_read(6'h30, d, r);
        n_checks++;
        if (d !== 32'h100 || r !== 2'b00) begin n_fail++; $display("FAIL ctrl_done got=%h/%b exp=00000100/00", d, r); end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(32 + i * 4), d, r);
            n_checks++;
            if (d !== ex[i] || r !== 2'b00) begin
                n_fail++; $display("FAIL result_rd[%0d] got=%h/%b exp=%h/00", i, d, r, ex[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(6'h24, 32'hDEADBEEF, 4'hF, r);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL result_wr_slverr got=%b exp=10", r); end
        axi_read(6'h24, d, r);
        n_checks++;
        if (d !== 32'h40506070) begin n_fail++; $display("FAIL result1_unchanged got=%h exp=40506070", d); end
        axi_read(6'h3C, d, r);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b11) begin n_fail++; $display("FAIL unmapped_rd got=%h/%b exp=00000000/11", d, r); end
        axi_write(6'h38, 32'h1234, 4'hF, r);
        n_checks++;
        if (r !== 2'b11) begin n_fail++; $display("FAIL unmapped_wr_decerr got=%b exp=11", r); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  r;
        logic [31:0] d;
        axi.S_AXI_WDATA  = 32'hA5A50001;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        cyc(1);
        axi.S_AXI_WVALID = 1'b0;
        n_checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 2'b10) begin
            n_fail++; $display("FAIL have_w_ready got=%b exp=10", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
        end
        cyc(2);
        axi.S_AXI_AWADDR  = 6'h10;
        axi.S_AXI_AWVALID = 1'b1;
        cyc(1);
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_AWADDR  = 6'h14;
        axi.S_AXI_WDATA   = 32'h5A5A0002;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 5'b10000) begin
                n_fail++;
                $display("FAIL b_hold[%0d] got=%b exp=10000", i,
                         {axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
            end
            cyc(1);
        end
        axi.S_AXI_BREADY = 1'b1;
        cyc(1);
        axi.S_AXI_BREADY = 1'b0;
        n_checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 3'b011) begin
            n_fail++; $display("FAIL after_b_idle got=%b exp=011", {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
        end
        cyc(1);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b1;
        for (int t = 0; t < 20 && !axi.S_AXI_BVALID; t++) cyc(1);
        n_checks++;
        if (axi.S_AXI_BVALID !== 1'b1 || axi.S_AXI_BRESP !== 2'b00) begin
            n_fail++; $display("FAIL second_wr_b got=%b/%b exp=1/00", axi.S_AXI_BVALID, axi.S_AXI_BRESP);
        end
        cyc(1);
        axi.S_AXI_BREADY = 1'b0;
        axi_read(6'h10, d, r);
        n_checks++;
        if (d !== 32'hA5A50001) begin n_fail++; $display("FAIL key0_first_wr got=%h exp=a5a50001", d); end
        axi_read(6'h14, d, r);
        n_checks++;
        if (d !== 32'h5A5A0002) begin n_fail++; $display("FAIL key1_second_wr got=%h exp=5a5a0002", d); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(6'h30, 32'h1, 4'hF, r);
        cyc(2);
        axi_read(6'h30, d, r);
        n_checks++;
        if (d !== 32'h100) begin n_fail++; $display("FAIL pre_reset_done got=%h exp=00000100", d); end
        axi.S_AXI_AWADDR  = 6'h34;
        axi.S_AXI_WDATA   = 32'h0;
        axi.S_AXI_ARADDR  = 6'h00;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;
        cyc(1);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        cyc(1);
        n_checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 2'b11) begin
            n_fail++; $display("FAIL both_valid got=%b exp=11", {axi.S_AXI_BVALID, axi.S_AXI_RVALID});
        end
        rst = 1'b1;
        cyc(1);
        n_checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid_drop got=%b exp=00", {axi.S_AXI_BVALID, axi.S_AXI_RVALID});
        end
        rst = 1'b0;
        cyc(1);
        axi.S_AXI_WDATA  = 32'hDEAD0000;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        cyc(1);
        axi.S_AXI_WVALID = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        axi_read(6'h00, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL state0_after_reset got=%h exp=0", d); end
        axi_read(6'h30, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL done_after_reset got=%h exp=0", d); end
        axi_write(6'h00, 32'h77, 4'hF, r);
        axi_read(6'h00, d, r);
        n_checks++;
        if (d !== 32'h77) begin n_fail++; $display("FAIL partial_w_discarded got=%h exp=00000077", d); end
    endtask

    task automatic test_wstrb();
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] exp_d;
`ifdef ARK_WSTRB_EN
        exp_d = 32'hFF00FF00;
`else
        exp_d = 32'h0;
`endif
        axi_write(6'h00, 32'hFFFFFFFF, 4'hF, r);
        axi_write(6'h00, 32'h0, 4'b0101, r);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL strb_bresp got=%b exp=00", r); end
        axi_read(6'h00, d, r);
        n_checks++;
        if (d !== exp_d) begin n_fail++; $display("FAIL strb_merge got=%h exp=%h", d, exp_d); end
    endtask

    initial begin
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWPROT  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARPROT  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;
        test_reset();
        test_state_rw();
        test_compute();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_wstrb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
